// File: rtl/reg_file_4x8.sv
// Four-entry register file with per-register enable, shared inc/dec/load/clear
// operation, two combinational read ports and a registered wrap flag.
module reg_file_4x8 #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       fun_sel,
  input  logic [3:0]       reg_en,
  input  logic [1:0]       sel_a,
  input  logic [1:0]       sel_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             wrap
);

  localparam logic [1:0] FN_DEC = 2'b00;
  localparam logic [1:0] FN_INC = 2'b01;
  localparam logic [1:0] FN_LD  = 2'b10;
  localparam logic [1:0] FN_CLR = 2'b11;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];
  logic             wrap_q;
  logic             wrap_d;

  // wrap only reflects counting roll-over, never load/clear values
  always_comb begin
    wrap_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_d[i] = r_q[i];
      if (reg_en[i]) begin
        unique case (fun_sel)
          FN_DEC: begin
            r_d[i] = r_q[i] - ONE;
            if (r_q[i] == '0) wrap_d = 1'b1;
          end
          FN_INC: begin
            r_d[i] = r_q[i] + ONE;
            if (r_q[i] == ONES) wrap_d = 1'b1;
          end
          FN_LD:  r_d[i] = data_in;
          FN_CLR: r_d[i] = '0;
          default: r_d[i] = r_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_q[i] <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
      wrap_q <= wrap_d;
    end
  end

  assign out_a = r_q[sel_a];
  assign out_b = r_q[sel_b];
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_reg_file_4x8.sv
// Directed + random scoreboard bench for reg_file_4x8.
// Expected register state is queued at drive time and popped after the edge.
module tb_reg_file_4x8;

  localparam logic [1:0] DEC = 2'b00;
  localparam logic [1:0] INC = 2'b01;
  localparam logic [1:0] LD  = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [1:0] fun_sel;
  logic [3:0] reg_en;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       wrap;

  typedef struct packed {
    logic [3:0][7:0] r;
    logic            w;
  } exp_t;

  exp_t            q[$];
  logic [3:0][7:0] mdl;
  int              checks = 0;
  int              errors = 0;

  reg_file_4x8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .fun_sel (fun_sel),
    .reg_en  (reg_en),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .out_a   (out_a),
    .out_b   (out_b),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reads all four registers through both ports and checks wrap.
  task automatic chk_all(input string tag,
                         input logic [3:0][7:0] r,
                         input logic w);
    sel_a = 2'd0; sel_b = 2'd1;
    #1;
    chk({tag, "_r0"}, out_a, r[0]);
    chk({tag, "_r1"}, out_b, r[1]);
    sel_a = 2'd2; sel_b = 2'd3;
    #1;
    chk({tag, "_r2"}, out_a, r[2]);
    chk({tag, "_r3"}, out_b, r[3]);
    chk({tag, "_wrap"}, {7'd0, wrap}, {7'd0, w});
  endtask

  task automatic step(input string tag,
                      input logic [1:0] fs,
                      input logic [3:0] en,
                      input logic [7:0] din,
                      input logic [1:0] sa);
    exp_t e;
    exp_t got;
    @(negedge clk);
    fun_sel = fs; reg_en = en; data_in = din;
    sel_a = sa; sel_b = ~sa;
    #1;
    chk({tag, "_pre_a"}, out_a, mdl[sa]);
    chk({tag, "_pre_b"}, out_b, mdl[~sa]);
    e.w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.r[i] = mdl[i];
      if (en[i]) begin
        case (fs)
          DEC: begin
            e.r[i] = mdl[i] - 8'd1;
            if (mdl[i] == 8'h00) e.w = 1'b1;
          end
          INC: begin
            e.r[i] = mdl[i] + 8'd1;
            if (mdl[i] == 8'hFF) e.w = 1'b1;
          end
          LD:  e.r[i] = din;
          default: e.r[i] = 8'h00;
        endcase
      end
    end
    q.push_back(e);
    mdl = e.r;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
    end else begin
      got = q.pop_front();
      chk_all(tag, got.r, got.w);
    end
    reg_en = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = 8'h00; fun_sel = DEC;
    reg_en = 4'b0000; sel_a = 2'd0; sel_b = 2'd0;
    mdl = '0;
    #1;
    chk("rst_a", out_a, 8'h00);
    chk("rst_b", out_b, 8'h00);
    chk_all("rst", mdl, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step("ld_r0r2", LD, 4'b0101, 8'h3C, 2'd0);
    step("ld_r2", LD, 4'b0100, 8'hA5, 2'd2);
    sel_a = 2'd0; sel_b = 2'd2;
    #1;
    chk("rd_a_3c", out_a, 8'h3C);
    chk("rd_b_a5", out_b, 8'hA5);
    sel_a = 2'd2;
    #1;
    chk("same_sel_a", out_a, 8'hA5);
    chk("same_sel_b", out_b, 8'hA5);

    step("ld_r1_ff", LD, 4'b0010, 8'hFF, 2'd1);
    step("inc_wrap", INC, 4'b0010, 8'h00, 2'd1);
    step("noop", INC, 4'b0000, 8'h00, 2'd1);

    step("clr_r3", CLR, 4'b1000, 8'h00, 2'd3);
    step("dec_wrap", DEC, 4'b1000, 8'h00, 2'd3);
    step("dec_fe", DEC, 4'b1000, 8'h00, 2'd3);

    step("ld_r0_10", LD, 4'b0001, 8'h10, 2'd0);
    step("ld_r1_ff2", LD, 4'b0010, 8'hFF, 2'd1);
    step("inc_multi", INC, 4'b0011, 8'h00, 2'd0);
    step("clr_all", CLR, 4'b1111, 8'h00, 2'd2);
    step("ld_ff_nowrap", LD, 4'b1111, 8'hFF, 2'd1);
    step("clr_nowrap", CLR, 4'b0001, 8'h00, 2'd0);

    step("ld_r2_07", LD, 4'b0100, 8'h07, 2'd2);
    step("rdw_r2_55", LD, 4'b0100, 8'h55, 2'd2);

    // Leave registers non-zero with wrap set, then reset between edges.
    step("ld_all_ff", LD, 4'b1111, 8'hFF, 2'd0);
    step("inc_r0_wrap", INC, 4'b0001, 8'h00, 2'd0);
    @(negedge clk);
    fun_sel = INC; reg_en = 4'b1111;
    #2;
    rst_n = 1'b0;
    mdl = '0;
    #1;
    chk_all("async_rst", mdl, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_edge", mdl, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    reg_en = 4'b0000;
    step("post_rst_inc", INC, 4'b1111, 8'h00, 2'd3);

    for (int k = 0; k < 24; k++) begin
      step("rand",
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_4x8.md
REG_FILE_4X8 -- requirements
Module: reg_file_4x8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every register and data port.
REQ-002 SHALL have parameter RST_VAL, default 8'h00, value loaded into every register on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port data_in  input  WIDTH  write data for the load function.
REQ-006 SHALL have port fun_sel  input  2  operation: 00 decrement, 01 increment, 10 load, 11 clear.
REQ-007 SHALL have port reg_en  input  4  per-register enable, active-high; bit i selects register Ri.
REQ-008 SHALL have port sel_a  input  2  read-port A register select (00 R0 .. 11 R3).
REQ-009 SHALL have port sel_b  input  2  read-port B register select (00 R0 .. 11 R3).
REQ-010 SHALL have port out_a  output  WIDTH  contents of the register chosen by sel_a; feeds the 4-to-1 operand mux.
REQ-011 SHALL have port out_b  output  WIDTH  contents of the register chosen by sel_b.
REQ-012 SHALL have port wrap  output  1  registered flag: last update edge produced an increment or decrement wrap-around.

Function
REQ-013 SHALL hold four WIDTH-bit registers R0..R3.
REQ-014 SHALL update, on each rising clk edge, every Ri with reg_en[i]=1 according to fun_sel; Ri with reg_en[i]=0 SHALL hold.
REQ-015 SHALL apply decrement as Ri <= Ri - 1 modulo 2^WIDTH (00 -> FF for WIDTH=8).
REQ-016 SHALL apply increment as Ri <= Ri + 1 modulo 2^WIDTH (FF -> 00 for WIDTH=8).
REQ-017 SHALL apply load as Ri <= data_in, and clear as Ri <= 0.
REQ-018 SHALL apply one fun_sel simultaneously to all enabled registers; each register operates on its own prior value.
REQ-019 SHALL treat reg_en=4'b0000 as a no-op for all registers; wrap SHALL be 0 after that edge.
REQ-020 SHALL drive out_a and out_b combinationally from the current register contents, with zero-cycle read latency.
REQ-021 SHALL return the pre-edge value on a read port that selects a register being written in the same cycle; the new value SHALL appear after the edge.
REQ-022 SHALL allow sel_a = sel_b; both ports then show the same register.
REQ-023 SHALL set wrap to 1 on an edge where any enabled register goes FF->00 under increment or 00->FF under decrement; otherwise wrap SHALL be 0 after that edge.
REQ-024 SHALL keep wrap at 0 for load and clear, even when data_in causes an FF/00 transition.
REQ-025 SHALL produce no X on outputs for any 2-bit select value; all codes are defined.

Reset
REQ-026 SHALL, while rst_n=0, force R0..R3 to RST_VAL and wrap to 0 immediately, independent of clk.
REQ-027 SHALL let reset override any operation in progress; an edge coinciding with rst_n=0 SHALL have no effect.
REQ-028 SHALL resume normal updates on the first rising clk edge after rst_n returns to 1.
REQ-029 SHALL, after reset with sel_a=sel_b=00, give out_a = out_b = RST_VAL (8'h00 by default).

Verification
REQ-030 SHALL cover load/read: load R0=8'h3C, R2=8'hA5 with reg_en=0101, data_in=8'h3C, then R2 separately; sel_a=00, sel_b=10 -> out_a=3C, out_b=A5, wrap=0.
REQ-031 SHALL cover increment wrap: R1=FF, fun_sel=01, reg_en=0010 -> R1=00, wrap=1; next edge with reg_en=0000 -> wrap=0.
REQ-032 SHALL cover decrement wrap: R3=00, fun_sel=00, reg_en=1000 -> R3=FF, wrap=1; a second decrement -> R3=FE, wrap=0.
REQ-033 SHALL cover multi-enable: R0=10, R1=FF, increment with reg_en=0011 -> R0=11, R1=00, wrap=1; clear with reg_en=1111 -> all 00, wrap=0.
REQ-034 SHALL cover read-during-write: R2=07, load 8'h55 into R2 with sel_a=10 -> out_a=07 before the edge, 55 after.
REQ-035 SHALL cover async reset mid-operation: registers non-zero, wrap=1, rst_n low between edges -> all registers 00 and wrap=0 with no clk edge; the edge during reset is ignored.
